btn_debounce_pulse: RTL

Debounces and synchronises one raw push-button input and converts it into a stable level plus single-cycle press/release pulses in the `clk` domain. It sits directly upstream of the switch-capture registers on the board top level. Its `btn_press` pulse drives their load enable, so the button never acts as a clock. Configurable for 100 MHz operation.

---
 rtl/btn_debounce_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/btn_debounce_pulse.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
// Timing defaults assume a 100 MHz system clock.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int unsigned BTN_STABLE_CYCLES_DEF = 1_000_000;   // 10 ms
    localparam int unsigned BTN_REPEAT_DELAY_DEF  = 50_000_000;  // 500 ms
    localparam int unsigned BTN_REPEAT_PERIOD_DEF = 10_000_000;  // 100 ms

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
// Synchronous active-high reset clears both stages.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from the same edge; blocking here would collapse
    // the two flops into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer: stable level plus one-cycle press/release pulses.
// Optional auto-repeat of btn_press is built when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module btn_debounce_pulse
    import btn_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = BTN_STABLE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY  = BTN_REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = BTN_REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             btn_sync;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, press_nxt, release_nxt;
    logic             rpt_fire;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end else if (rpt_fire) begin
                    press_nxt = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
    logic             rpt_armed, rpt_armed_nxt;  // first (long) delay already served

    assign rpt_fire = (state == PRESSED) && btn_sync &&
                      (rpt_cnt == (rpt_armed ? RPT_PERIOD_LAST : RPT_DELAY_LAST));

    // Counts only while held in PRESSED; a bounce through RELEASE_WAIT keeps its progress.
    always_comb begin
        rpt_cnt_nxt   = rpt_cnt;
        rpt_armed_nxt = rpt_armed;
        if (state_nxt == IDLE || state_nxt == PRESS_WAIT) begin
            rpt_cnt_nxt   = '0;
            rpt_armed_nxt = 1'b0;
        end else if (state == PRESSED && btn_sync) begin
            if (rpt_fire) begin
                rpt_cnt_nxt   = '0;
                rpt_armed_nxt = 1'b1;
            end else begin
                rpt_cnt_nxt = rpt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt_nxt;
            rpt_armed <= rpt_armed_nxt;
        end
    end
`else
    logic unused_repeat_cfg;

    assign rpt_fire          = 1'b0;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};  // repeat timing has no effect here
`endif

endmodule
